// File: rtl/dnn_result_collector.sv
// dnn_result_collector
// Issues detection-NN evaluations in groups of LANES parallel instances and
// packs the 1-bit results into RESULT_W-bit pages. A frame consists of
// NUM_PAGES pages; the final page holds only LAST_PAGE_CNT results. Each page
// carries a valid-result count, a hit (popcount) count and its page index.
// A synchronous flush abandons the current frame and restarts at page 0.

module dnn_result_collector #(
    parameter int RESULT_W      = 512,
    parameter int NUM_PAGES     = 3,
    parameter int LAST_PAGE_CNT = 62,
    parameter int LANES         = 1,
    parameter int CNT_W         = $clog2(RESULT_W + 1),
    parameter int PG_W          = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    // upstream window/feature stage
    input  logic                prev_out_ready,
    output logic                in_ready,
    // detection-NN lanes
    output logic [LANES-1:0]    start_det_nn,
    input  logic [LANES-1:0]    det_nn_done,
    input  logic [LANES-1:0]    det_nn_result,
    // downstream post-processing stage
    output logic                out_ready,
    input  logic                next_in_ready,
    output logic [RESULT_W-1:0] results,
    output logic [CNT_W-1:0]    result_cnt,
    output logic [CNT_W-1:0]    hit_cnt,
    output logic [PG_W-1:0]     page_idx,
    output logic                last_page
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Sizes are held one bit wider than the counters so the comparison
    // against a full page cannot wrap.
    localparam logic [CNT_W:0]  FULL_SIZE = (CNT_W + 1)'(RESULT_W);
    localparam logic [CNT_W:0]  LAST_SIZE = (CNT_W + 1)'(LAST_PAGE_CNT);
    localparam logic [CNT_W:0]  GROUP_INC = (CNT_W + 1)'(LANES);
    localparam logic [PG_W-1:0] LAST_PG   = PG_W'(NUM_PAGES - 1);

    // FSM state
    logic [1:0]          state_q;
    logic [1:0]          state_d;

    // Per-lane sticky completion flags and latched results
    logic [LANES-1:0]    flags_q;
    logic [LANES-1:0]    flags_d;
    logic [LANES-1:0]    lat_q;
    logic [LANES-1:0]    lat_d;

    // Page datapath
    logic [RESULT_W-1:0] results_q;
    logic [RESULT_W-1:0] results_d;
    logic [CNT_W-1:0]    result_cnt_q;
    logic [CNT_W-1:0]    result_cnt_d;
    logic [CNT_W-1:0]    hit_cnt_q;
    logic [CNT_W-1:0]    hit_cnt_d;
    logic [PG_W-1:0]     page_idx_q;
    logic [PG_W-1:0]     page_idx_d;

    // Group evaluation helpers
    logic                in_wait;
    logic [LANES-1:0]    flags_now;
    logic [LANES-1:0]    grp_res;
    logic                group_done;
    logic [RESULT_W-1:0] grp_ext;
    logic [CNT_W-1:0]    grp_hits;
    logic [CNT_W:0]      cnt_sum;
    logic [CNT_W:0]      page_size;
    logic                page_full;
    logic                last_page_w;

    assign in_wait     = (state_q == S_WAIT);
    assign last_page_w = (page_idx_q == LAST_PG);

    // Per-lane view of the group: a lane counts as finished if its flag is
    // already set or its done arrives this cycle. A lane that already
    // finished keeps its first result; repeat dones cannot overwrite it.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign flags_now[gi] = flags_q[gi] | det_nn_done[gi];
            assign grp_res[gi]   = flags_q[gi] ? lat_q[gi] : det_nn_result[gi];
            assign flags_d[gi]   = in_wait & ~flush & ~group_done & flags_now[gi];
            assign lat_d[gi]     = (in_wait & ~flags_q[gi] & det_nn_done[gi])
                                   ? det_nn_result[gi] : lat_q[gi];
        end
    endgenerate

    assign group_done = in_wait & (&flags_now);
    assign cnt_sum    = {1'b0, result_cnt_q} + GROUP_INC;
    assign page_size  = last_page_w ? LAST_SIZE : FULL_SIZE;
    assign page_full  = (cnt_sum == page_size);

    // Zero-extend the group results so they can be shifted into place.
    always_comb begin
        grp_ext              = '0;
        grp_ext[LANES-1:0]   = grp_res;
    end

    // Popcount of the group being committed.
    always_comb begin
        grp_hits = '0;
        for (int k = 0; k < LANES; k++) begin
            grp_hits = grp_hits + CNT_W'(grp_res[k]);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (prev_out_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (group_done) begin
                    state_d = page_full ? S_DONE : S_IDLE;
                end
            end
            S_DONE: begin
                if (next_in_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d = S_IDLE;
        end
    end

    // FSM outputs; the start pulse follows prev_out_ready combinationally.
    always_comb begin
        in_ready     = (state_q == S_IDLE);
        out_ready    = (state_q == S_DONE);
        start_det_nn = '0;
        if ((state_q == S_IDLE) && prev_out_ready && !flush) begin
            start_det_nn = '1;
        end
    end

    // Page datapath next-state: commit a finished group, clear on handshake,
    // or wipe everything on flush.
    always_comb begin
        results_d    = results_q;
        result_cnt_d = result_cnt_q;
        hit_cnt_d    = hit_cnt_q;
        page_idx_d   = page_idx_q;
        if (flush) begin
            results_d    = '0;
            result_cnt_d = '0;
            hit_cnt_d    = '0;
            page_idx_d   = '0;
        end else if (group_done) begin
            // Results are cleared at page start, so OR-ing places the group
            // at bits [result_cnt +: LANES] without disturbing the rest.
            results_d    = results_q | (grp_ext << result_cnt_q);
            result_cnt_d = cnt_sum[CNT_W-1:0];
            hit_cnt_d    = hit_cnt_q + grp_hits;
        end else if ((state_q == S_DONE) && next_in_ready) begin
            results_d    = '0;
            result_cnt_d = '0;
            hit_cnt_d    = '0;
            page_idx_d   = last_page_w ? '0 : page_idx_q + PG_W'(1);
        end
    end

    // Page datapath and lane flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            results_q    <= '0;
            result_cnt_q <= '0;
            hit_cnt_q    <= '0;
            page_idx_q   <= '0;
            flags_q      <= '0;
            lat_q        <= '0;
        end else begin
            results_q    <= results_d;
            result_cnt_q <= result_cnt_d;
            hit_cnt_q    <= hit_cnt_d;
            page_idx_q   <= page_idx_d;
            flags_q      <= flags_d;
            lat_q        <= lat_d;
        end
    end

    assign results    = results_q;
    assign result_cnt = result_cnt_q;
    assign hit_cnt    = hit_cnt_q;
    assign page_idx   = page_idx_q;
    assign last_page  = last_page_w;

endmodule

// File: tb/tb_dnn_result_collector.sv
// Testbench for dnn_result_collector with four lanes and small pages.
// Expected pages are built by a bench-side model as groups are driven,
// pushed to a scoreboard queue, and popped when the DUT raises out_ready.

module tb_dnn_result_collector;

    localparam int RESULT_W      = 16;
    localparam int NUM_PAGES     = 3;
    localparam int LAST_PAGE_CNT = 8;
    localparam int LANES         = 4;
    localparam int CNT_W         = $clog2(RESULT_W + 1);
    localparam int PG_W          = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1;

    typedef struct packed {
        logic [RESULT_W-1:0] res;
        logic [CNT_W-1:0]    cnt;
        logic [CNT_W-1:0]    hit;
        logic [PG_W-1:0]     pg;
        logic                last;
    } page_t;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                flush = 1'b0;
    logic                prev_out_ready = 1'b0;
    logic                in_ready;
    logic [LANES-1:0]    start_det_nn;
    logic [LANES-1:0]    det_nn_done = '0;
    logic [LANES-1:0]    det_nn_result = '0;
    logic                out_ready;
    logic                next_in_ready = 1'b0;
    logic [RESULT_W-1:0] results;
    logic [CNT_W-1:0]    result_cnt;
    logic [CNT_W-1:0]    hit_cnt;
    logic [PG_W-1:0]     page_idx;
    logic                last_page;

    int checks = 0;
    int failures = 0;

    page_t sb_q[$];
    logic [RESULT_W-1:0] m_res;
    int                  m_cnt;
    int                  m_hit;
    int                  m_pg;

    dnn_result_collector #(
        .RESULT_W      (RESULT_W),
        .NUM_PAGES     (NUM_PAGES),
        .LAST_PAGE_CNT (LAST_PAGE_CNT),
        .LANES         (LANES),
        .CNT_W         (CNT_W),
        .PG_W          (PG_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .prev_out_ready (prev_out_ready),
        .in_ready       (in_ready),
        .start_det_nn   (start_det_nn),
        .det_nn_done    (det_nn_done),
        .det_nn_result  (det_nn_result),
        .out_ready      (out_ready),
        .next_in_ready  (next_in_ready),
        .results        (results),
        .result_cnt     (result_cnt),
        .hit_cnt        (hit_cnt),
        .page_idx       (page_idx),
        .last_page      (last_page)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_clear();
        m_res = '0;
        m_cnt = 0;
        m_hit = 0;
        m_pg  = 0;
        sb_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  32'(in_ready), 32'd1);
        check({tag, "_out_ready"}, 32'(out_ready), 32'd0);
        check({tag, "_start"},     32'(start_det_nn), 32'd0);
        check({tag, "_results"},   32'(results), 32'd0);
        check({tag, "_cnt"},       32'(result_cnt), 32'd0);
        check({tag, "_hit"},       32'(hit_cnt), 32'd0);
        check({tag, "_page"},      32'(page_idx), 32'd0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && !in_ready; i++) begin
            step();
        end
        check("wait_in_ready", 32'(in_ready), 32'd1);
    endtask

    // One group: start in IDLE, then dones either together or staggered over
    // three cycles with repeat dones on lane 0 carrying a flipped result.
    task automatic do_group(input logic [LANES-1:0] res, input bit stagger);
        int psize;
        wait_idle();
        prev_out_ready = 1'b1;
        #1;
        check("start_pulse", 32'(start_det_nn), 32'hF);
        step();
        prev_out_ready = 1'b0;
        if (!stagger) begin
            det_nn_done   = 4'hF;
            det_nn_result = res;
            step();
        end else begin
            det_nn_done   = 4'b0001;
            det_nn_result = ~res;
            det_nn_result[0] = res[0];
            step();
            check("stag_wait0", 32'({in_ready, out_ready}), 32'd0);
            det_nn_done   = 4'b0101;
            det_nn_result = ~res;
            det_nn_result[2] = res[2];
            step();
            check("stag_wait1", 32'({in_ready, out_ready}), 32'd0);
            det_nn_done   = 4'b1011;
            det_nn_result = res;
            det_nn_result[0] = ~res[0];
            step();
        end
        det_nn_done = '0;
        // Model update
        m_res = m_res | (RESULT_W'(res) << m_cnt);
        m_cnt = m_cnt + LANES;
        m_hit = m_hit + $countones(res);
        check("grp_results", 32'(results), 32'(m_res));
        check("grp_cnt", 32'(result_cnt), 32'(m_cnt));
        check("grp_hit", 32'(hit_cnt), 32'(m_hit));
        psize = (m_pg == NUM_PAGES - 1) ? LAST_PAGE_CNT : RESULT_W;
        if (m_cnt == psize) begin
            sb_q.push_back('{res: m_res, cnt: CNT_W'(m_cnt), hit: CNT_W'(m_hit),
                             pg: PG_W'(m_pg), last: (m_pg == NUM_PAGES - 1)});
            m_res = '0;
            m_cnt = 0;
            m_hit = 0;
            m_pg  = (m_pg == NUM_PAGES - 1) ? 0 : m_pg + 1;
        end
    endtask

    // Consume a completed page, holding DONE for `hold` cycles first while
    // upstream requests and stray dones are presented.
    task automatic page_handshake(input int hold);
        page_t exp;
        for (int i = 0; i < 10 && !out_ready; i++) begin
            step();
        end
        check("page_out_ready", 32'(out_ready), 32'd1);
        check("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() == 0) return;
        exp = sb_q.pop_front();
        check("page_results", 32'(results), 32'(exp.res));
        check("page_cnt", 32'(result_cnt), 32'(exp.cnt));
        check("page_hit", 32'(hit_cnt), 32'(exp.hit));
        check("page_idx", 32'(page_idx), 32'(exp.pg));
        check("page_last", 32'(last_page), 32'(exp.last));
        prev_out_ready = 1'b1;
        for (int i = 0; i < hold; i++) begin
            det_nn_done   = (i % 3 == 0) ? 4'hF : 4'h0;
            det_nn_result = 4'hF;
            #1;
            check("hold_start", 32'(start_det_nn), 32'd0);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            step();
            check("hold_results", 32'(results), 32'(exp.res));
            check("hold_cnt", 32'(result_cnt), 32'(exp.cnt));
        end
        det_nn_done    = '0;
        prev_out_ready = 1'b0;
        next_in_ready  = 1'b1;
        step();
        next_in_ready  = 1'b0;
        check("hs_results", 32'(results), 32'd0);
        check("hs_cnt", 32'(result_cnt), 32'd0);
        check("hs_hit", 32'(hit_cnt), 32'd0);
        check("hs_in_ready", 32'(in_ready), 32'd1);
        check("hs_page_idx", 32'(page_idx), 32'(m_pg));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LANES-1:0] r;
        model_clear();

        // Reset values
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        step();

        // Page 0: first group staggered (1,0,1,1), then alternating 1,0
        do_group(4'b1101, 1'b1);
        for (int g = 0; g < 3; g++) do_group(4'b0101, 1'b0);
        page_handshake(20);

        // Page 1: mixed random groups
        for (int g = 0; g < RESULT_W / LANES; g++) begin
            r = LANES'($urandom);
            do_group(r, g[0]);
        end
        page_handshake(2);

        // Page 2 (last, 8 results); handshake wraps page_idx to 0
        do_group(4'b1111, 1'b0);
        do_group(4'b1010, 1'b1);
        check("last_page_flag", 32'(last_page), 32'd1);
        page_handshake(1);
        check("wrap_page0", 32'(page_idx), 32'd0);

        // Flush in WAIT_NN on page 1 with result_cnt=8
        for (int g = 0; g < 4; g++) do_group(4'b0110, 1'b0);
        page_handshake(0);
        do_group(4'b1111, 1'b0);
        do_group(4'b0011, 1'b0);
        check("pre_flush_cnt", 32'(result_cnt), 32'd8);
        wait_idle();
        prev_out_ready = 1'b1;
        step();
        prev_out_ready = 1'b0;
        flush         = 1'b1;
        det_nn_done   = 4'hF;
        det_nn_result = 4'hF;
        step();
        flush       = 1'b0;
        det_nn_done = '0;
        model_clear();
        check_reset_outputs("flush");
        // Stray dones in IDLE are ignored
        det_nn_done = 4'hF;
        step();
        det_nn_done = '0;
        check("stray_cnt", 32'(result_cnt), 32'd0);
        check("stray_in_ready", 32'(in_ready), 32'd1);
        // Flush in IDLE suppresses the start pulse and the transition
        prev_out_ready = 1'b1;
        flush          = 1'b1;
        #1;
        check("flush_start", 32'(start_det_nn), 32'd0);
        step();
        prev_out_ready = 1'b0;
        flush          = 1'b0;
        check("flush_stay_idle", 32'(in_ready), 32'd1);

        // Asynchronous reset mid-page (page 1, inside WAIT_NN)
        for (int g = 0; g < 4; g++) do_group(4'b1001, 1'b0);
        page_handshake(0);
        do_group(4'b0111, 1'b0);
        prev_out_ready = 1'b1;
        step();
        prev_out_ready = 1'b0;
        check("pre_rst_wait", 32'(in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Normal operation resumes
        for (int g = 0; g < 4; g++) begin
            r = LANES'($urandom);
            do_group(r, g[0]);
        end
        page_handshake(3);
        check("resume_page1", 32'(page_idx), 32'd1);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
